// File: rtl/fpga_link_pkg.sv
// fpga_link_pkg
// Shared definitions for the FPGA-to-FPGA serial link (transmitter and receiver):
//   - rx_state_t      : receiver FSM states
//   - DEF_* constants : default frame width, ack length and synchronizer depth
//   - is_ack_state()  : true for states that drive ack
package fpga_link_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_ACK_LEN     = 2;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_ACK_START,
        RX_WAIT_BIT,
        RX_ACK_BIT,
        RX_WAIT_STOP,
        RX_ACK_STOP
    } rx_state_t;

    function automatic logic is_ack_state(input rx_state_t s);
        return (s == RX_ACK_START) || (s == RX_ACK_BIT) || (s == RX_ACK_STOP);
    endfunction

endpackage

// File: rtl/fpga_sync.sv
// fpga_sync
// Single-bit multi-flop synchronizer for asynchronous link inputs.
// Ports:
//   clk   in  : destination clock
//   reset in  : synchronous, active-high; clears every stage
//   d     in  : asynchronous input
//   q     out : synchronized output, STAGES cycles behind d
module fpga_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (reset) ff <= '0;
        else       ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/fpga_receiver_state.sv
// fpga_receiver_state
// Receive-side controller of the FPGA-to-FPGA serial link. Each frame is a start
// handshake, DATA_W bit handshakes (LSB first) and a stop handshake; every
// handshake is a rising edge on req_in answered by ack held for ACK_LEN cycles.
// Optional feature macro: FPGA_RX_TIMEOUT_EN (inter-handshake watchdog).
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   req_in      : async handshake strobe from the remote transmitter
//   data_in     : async serial data bit, stable around req_in
//   ack         : registered handshake acknowledge
//   busy        : high while the FSM is not idle
//   data_out    : last completed word, held until the next frame completes
//   data_valid  : one-cycle pulse when data_out updates
//   frame_err   : one-cycle pulse on watchdog abort (0 without the watchdog)
module fpga_receiver_state
    import fpga_link_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ACK_LEN     = DEF_ACK_LEN,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT     = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_in,
    input  logic              data_in,
    output logic              ack,
    output logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int AW    = $clog2(ACK_LEN + 1);

    rx_state_t         state, state_nxt;
    logic              req_s, data_s, req_prev, req_edge;
    logic [CNT_W-1:0]  bit_cnt;
    logic [AW-1:0]     ack_cnt, ack_cnt_nxt;
    logic [DATA_W-1:0] shift_reg;
    logic              ack_last;
    logic              wd_expired;

    fpga_sync #(.STAGES(SYNC_STAGES)) u_sync_req (
        .clk(clk), .reset(reset), .d(req_in), .q(req_s)
    );
    fpga_sync #(.STAGES(SYNC_STAGES)) u_sync_data (
        .clk(clk), .reset(reset), .d(data_in), .q(data_s)
    );

    always_ff @(posedge clk) begin
        if (reset) req_prev <= 1'b0;
        else       req_prev <= req_s;
    end

    assign req_edge = req_s & ~req_prev;
    assign ack_last = (ack_cnt == AW'(ACK_LEN - 1));

`ifdef FPGA_RX_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wdog;

    // Counts only while waiting for a handshake; any state change restarts it.
    always_ff @(posedge clk) begin
        if (reset)                   wdog <= '0;
        else if (state_nxt != state) wdog <= '0;
        else if (state == RX_WAIT_BIT || state == RX_WAIT_STOP)
                                     wdog <= wdog + WW'(1);
        else                         wdog <= '0;
    end

    assign wd_expired = (wdog == WW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) frame_err <= 1'b0;
        else       frame_err <= wd_expired && !req_edge &&
                                (state == RX_WAIT_BIT || state == RX_WAIT_STOP);
    end
`else
    assign wd_expired = 1'b0;
    assign frame_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RX_IDLE;
            ack_cnt <= '0;
        end else begin
            state   <= state_nxt;
            ack_cnt <= ack_cnt_nxt;
        end
    end

    // ack_cnt_nxt defaults to 0 so every ack window starts counting from zero.
    always_comb begin
        state_nxt   = state;
        ack_cnt_nxt = '0;
        case (state)
            RX_IDLE:
                if (req_edge) state_nxt = RX_ACK_START;
            RX_ACK_START:
                if (ack_last) state_nxt = RX_WAIT_BIT;
                else          ack_cnt_nxt = ack_cnt + AW'(1);
            RX_WAIT_BIT:
                if (req_edge)        state_nxt = RX_ACK_BIT;
                else if (wd_expired) state_nxt = RX_IDLE;
            RX_ACK_BIT:
                if (ack_last)
                    state_nxt = (bit_cnt == CNT_W'(DATA_W)) ? RX_WAIT_STOP : RX_WAIT_BIT;
                else
                    ack_cnt_nxt = ack_cnt + AW'(1);
            RX_WAIT_STOP:
                if (req_edge)        state_nxt = RX_ACK_STOP;
                else if (wd_expired) state_nxt = RX_IDLE;
            RX_ACK_STOP:
                if (ack_last) state_nxt = RX_IDLE;
                else          ack_cnt_nxt = ack_cnt + AW'(1);
            default:
                state_nxt = RX_IDLE;
        endcase
    end

    // Bit capture: the word is cleared at the start handshake, then each bit
    // handshake writes position bit_cnt. bit_cnt stops at DATA_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (state == RX_IDLE && req_edge) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (state == RX_WAIT_BIT && req_edge) begin
            for (int i = 0; i < DATA_W; i++)
                if (CNT_W'(i) == bit_cnt) shift_reg[i] <= data_s;
            if (bit_cnt != CNT_W'(DATA_W)) bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    // Outputs are registered from the next state so they line up with it.
    // data_valid/data_out land on the last ACK_STOP cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack        <= 1'b0;
            busy       <= 1'b0;
            data_valid <= 1'b0;
            data_out   <= '0;
        end else begin
            ack        <= is_ack_state(state_nxt);
            busy       <= (state_nxt != RX_IDLE);
            data_valid <= 1'b0;
            if (state_nxt == RX_ACK_STOP && ack_cnt_nxt == AW'(ACK_LEN - 1)) begin
                data_valid <= 1'b1;
                data_out   <= shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_fpga_receiver_state.sv
// tb_fpga_receiver_state
// Directed bench for fpga_receiver_state: DATA_W=8, ACK_LEN=2, SYNC_STAGES=3,
// TIMEOUT=16. The watchdog case is only exercised when FPGA_RX_TIMEOUT_EN is set.
module tb_fpga_receiver_state;

    localparam int DATA_W = 8;
    localparam int ACK_LEN = 2;
    localparam int SYNC = 3;

    logic clk = 1'b0;
    logic reset, req_in, data_in;
    logic ack, busy, data_valid, frame_err;
    logic [DATA_W-1:0] data_out;

    int n_cmp = 0;
    int n_bad = 0;

    // monitor state
    int ack_rises = 0;
    int ack_bad_len = 0;
    int ack_len = 0;
    int dv_cnt = 0;
    logic [DATA_W-1:0] dv_word = '0;
    logic ack_q = 1'b0;

    always #5 clk = ~clk;

    fpga_receiver_state #(
        .DATA_W(DATA_W), .ACK_LEN(ACK_LEN), .SYNC_STAGES(SYNC), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset), .req_in(req_in), .data_in(data_in),
        .ack(ack), .busy(busy), .data_out(data_out),
        .data_valid(data_valid), .frame_err(frame_err)
    );

    // Sample once per cycle away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            ack_q   <= 1'b0;
            ack_len <= 0;
        end else begin
            if (ack && !ack_q) ack_rises <= ack_rises + 1;
            if (ack) ack_len <= ack_len + 1;
            if (!ack && ack_q) begin
                if (ack_len != ACK_LEN) ack_bad_len <= ack_bad_len + 1;
                ack_len <= 0;
            end
            ack_q <= ack;
            if (data_valid) begin
                dv_cnt  <= dv_cnt + 1;
                dv_word <= data_out;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ack(input logic lvl);
        int n = 0;
        while (ack !== lvl && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) chk("ack_wait_timeout", 32'(ack), 32'(lvl));
    endtask

    // One handshake. glitch=1 adds a one-cycle low pulse on req_in right after
    // the rise, so a second synchronized edge lands while ack is already high.
    task automatic send_hs(input logic d, input bit glitch);
        @(negedge clk);
        data_in = d;
        req_in  = 1'b1;
        if (glitch) begin
            @(negedge clk) req_in = 1'b0;
            @(negedge clk) req_in = 1'b1;
        end
        wait_ack(1'b1);
        req_in = 1'b0;
        wait_ack(1'b0);
        @(negedge clk);
    endtask

    task automatic send_bits(input logic [DATA_W-1:0] w, input int glitch_bit);
        for (int i = 0; i < DATA_W; i++) send_hs(w[i], (i == glitch_bit));
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] w, input int glitch_bit);
        send_hs(1'b0, 1'b0);
        send_bits(w, glitch_bit);
        send_hs(1'b0, 1'b0);
    endtask

    initial begin
        int r0, v0, n;
        reset = 1'b1; req_in = 1'b0; data_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_data_valid", 32'(data_valid), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Frame 0xA5 with a measured start handshake: ack on 4th edge after req_in.
        r0 = ack_rises; v0 = dv_cnt;
        req_in = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (ack !== 1'b1 && n < 20);
        chk("ack_latency", 32'(n), 32'(SYNC + 1));
        chk("busy_with_ack", 32'(busy), 1);
        @(negedge clk);
        req_in = 1'b0;
        wait_ack(1'b0);
        @(negedge clk);
        send_bits(8'hA5, -1);
        send_hs(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("a5_ack_count", 32'(ack_rises - r0), 10);
        chk("ack_len_ok", 32'(ack_bad_len), 0);
        chk("a5_valid_count", 32'(dv_cnt - v0), 1);
        chk("a5_word_at_valid", 32'(dv_word), 32'hA5);
        chk("a5_data_out", 32'(data_out), 32'hA5);
        chk("a5_busy_low", 32'(busy), 0);

        // Back-to-back 0x00 then 0xFF.
        r0 = ack_rises; v0 = dv_cnt;
        send_frame(8'h00, -1);
        chk("b2b_first_valid", 32'(dv_cnt - v0), 1);
        chk("b2b_first_word", 32'(dv_word), 32'h00);
        send_frame(8'hFF, -1);
        repeat (3) @(negedge clk);
        chk("b2b_valid_count", 32'(dv_cnt - v0), 2);
        chk("b2b_second_word", 32'(dv_word), 32'hFF);
        chk("b2b_ack_count", 32'(ack_rises - r0), 20);

        // Spurious req edge during ACK_BIT of bit 2 must be ignored.
        r0 = ack_rises; v0 = dv_cnt;
        send_frame(8'h5A, 2);
        repeat (3) @(negedge clk);
        chk("glitch_ack_count", 32'(ack_rises - r0), 10);
        chk("glitch_valid_count", 32'(dv_cnt - v0), 1);
        chk("glitch_word", 32'(data_out), 32'h5A);
        chk("ack_len_ok2", 32'(ack_bad_len), 0);

        // Reset after 4 bits, then a clean 0x3C frame.
        send_hs(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_hs(1'b1, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("midrst_ack", 32'(ack), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_data_out", 32'(data_out), 0);
        chk("midrst_data_valid", 32'(data_valid), 0);
        repeat (2) @(negedge clk);
        v0 = dv_cnt;
        send_frame(8'h3C, -1);
        repeat (3) @(negedge clk);
        chk("post_rst_valid", 32'(dv_cnt - v0), 1);
        chk("post_rst_word", 32'(data_out), 32'h3C);

`ifdef FPGA_RX_TIMEOUT_EN
        // Stall after 3 bits: frame_err 16 edges after entering WAIT_BIT.
        send_hs(1'b0, 1'b0);
        send_hs(1'b1, 1'b0);
        send_hs(1'b1, 1'b0);
        @(negedge clk);
        data_in = 1'b1;
        req_in  = 1'b1;
        wait_ack(1'b1);
        req_in = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (ack !== 1'b0 && n < 20);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (frame_err !== 1'b1 && n < 40);
        chk("to_cycles", 32'(n), 16);
        chk("to_busy_low", 32'(busy), 0);
        chk("to_data_kept", 32'(data_out), 32'h3C);
        @(posedge clk); #1;
        chk("to_pulse_one_cycle", 32'(frame_err), 0);
`else
        chk("frame_err_tied", 32'(frame_err), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
